// File: rtl/segre_dcache_tag_sa_if.sv
// Lookup, fill and invalidate bundle for the set-associative data-cache tag array.
// The master drives requests; the slave (tag array) returns registered results.
interface segre_dcache_tag_sa_if #(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned NUM_WAYS = 4,
    parameter int unsigned TAG_SIZE = 8
);
    localparam int unsigned SET_SIZE = $clog2(NUM_SETS);
    localparam int unsigned WAY_SIZE = $clog2(NUM_WAYS);

    logic                req_i;
    logic                store_i;
    logic [SET_SIZE-1:0] set_i;
    logic [TAG_SIZE-1:0] tag_i;
    logic                fill_i;
    logic [SET_SIZE-1:0] fill_set_i;
    logic [WAY_SIZE-1:0] fill_way_i;
    logic [TAG_SIZE-1:0] fill_tag_i;
    logic                fill_dirty_i;
    logic                invalidate_i;
    logic                hit_o;
    logic                miss_o;
    logic [WAY_SIZE-1:0] way_o;
    logic                victim_valid_o;
    logic                victim_dirty_o;
    logic [TAG_SIZE-1:0] victim_tag_o;
    logic                busy_o;

    modport master (
        output req_i, store_i, set_i, tag_i,
        output fill_i, fill_set_i, fill_way_i, fill_tag_i, fill_dirty_i,
        output invalidate_i,
        input  hit_o, miss_o, way_o, victim_valid_o, victim_dirty_o, victim_tag_o, busy_o
    );

    modport slave (
        input  req_i, store_i, set_i, tag_i,
        input  fill_i, fill_set_i, fill_way_i, fill_tag_i, fill_dirty_i,
        input  invalidate_i,
        output hit_o, miss_o, way_o, victim_valid_o, victim_dirty_o, victim_tag_o, busy_o
    );
endinterface

// File: rtl/segre_dcache_tag_sa.sv
// Set-associative data-cache tag array with LRU ages, single-cycle lookup, fill port
// and a one-set-per-cycle global invalidate sweep.
module segre_dcache_tag_sa #(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned NUM_WAYS = 4,
    parameter int unsigned TAG_SIZE = 8
) (
    input logic                  clk_i,
    input logic                  rsn_i,
    segre_dcache_tag_sa_if.slave bus
);
    localparam int unsigned SET_SIZE = $clog2(NUM_SETS);
    localparam int unsigned WAY_SIZE = $clog2(NUM_WAYS);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e              state_q;
    logic [SET_SIZE-1:0] cnt_q;

    logic                valid_q [NUM_SETS][NUM_WAYS];
    logic                dirty_q [NUM_SETS][NUM_WAYS];
    logic [TAG_SIZE-1:0] tag_q   [NUM_SETS][NUM_WAYS];
    logic [WAY_SIZE-1:0] age_q   [NUM_SETS][NUM_WAYS];

    logic                hit_q, miss_q, victim_valid_q, victim_dirty_q;
    logic [WAY_SIZE-1:0] way_q;
    logic [TAG_SIZE-1:0] victim_tag_q;

    logic                lookup_acc, fill_acc, lookup_hit, found_invalid;
    logic [WAY_SIZE:0]   n_match;
    logic [WAY_SIZE-1:0] hit_way, victim_way;
    logic [WAY_SIZE-1:0] hit_old_age, fill_old_age;
    logic [WAY_SIZE-1:0] hit_age  [NUM_WAYS];
    logic [WAY_SIZE-1:0] fill_age [NUM_WAYS];
    logic                same_set, drop_store;

    assign lookup_acc = bus.req_i && (state_q == StIdle);
    assign fill_acc   = bus.fill_i && (state_q == StIdle);
    assign same_set   = fill_acc && (bus.fill_set_i == bus.set_i);
    // A fill into the very line being stored to overwrites the store's dirty update.
    assign drop_store = same_set && (bus.fill_way_i == hit_way);

    always_comb begin
        n_match       = '0;
        hit_way       = '0;
        victim_way    = '0;
        found_invalid = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[bus.set_i][w] && (tag_q[bus.set_i][w] == bus.tag_i)) begin
                n_match = n_match + 1'b1;
                hit_way = WAY_SIZE'(w);
            end
        end
        lookup_hit = (n_match == (WAY_SIZE+1)'(1));
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found_invalid && !valid_q[bus.set_i][w]) begin
                found_invalid = 1'b1;
                victim_way    = WAY_SIZE'(w);
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[bus.set_i][w] == WAY_SIZE'(NUM_WAYS - 1)) victim_way = WAY_SIZE'(w);
            end
        end
    end

    // New age vectors for the looked-up set and the filled set if the access is applied.
    always_comb begin
        hit_old_age  = age_q[bus.set_i][hit_way];
        fill_old_age = age_q[bus.fill_set_i][bus.fill_way_i];
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_age[w]  = age_q[bus.set_i][w];
            fill_age[w] = age_q[bus.fill_set_i][w];
            if (WAY_SIZE'(w) == hit_way) begin
                hit_age[w] = '0;
            end else if (age_q[bus.set_i][w] < hit_old_age) begin
                hit_age[w] = age_q[bus.set_i][w] + 1'b1;
            end
            if (WAY_SIZE'(w) == bus.fill_way_i) begin
                fill_age[w] = '0;
            end else if (age_q[bus.fill_set_i][w] < fill_old_age) begin
                fill_age[w] = age_q[bus.fill_set_i][w] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.invalidate_i) state_q <= StFlush;
                end
                StFlush: begin
                    if (cnt_q == SET_SIZE'(NUM_SETS - 1)) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    age_q[s][w]   <= WAY_SIZE'(w);
                end
            end
        end else if (state_q == StFlush) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_q[cnt_q][w] <= 1'b0;
                dirty_q[cnt_q][w] <= 1'b0;
                age_q[cnt_q][w]   <= WAY_SIZE'(w);
            end
        end else begin
            if (lookup_acc && lookup_hit) begin
                if (!same_set) begin
                    for (int w = 0; w < NUM_WAYS; w++) age_q[bus.set_i][w] <= hit_age[w];
                end
                if (bus.store_i && !drop_store) dirty_q[bus.set_i][hit_way] <= 1'b1;
            end
            if (fill_acc) begin
                valid_q[bus.fill_set_i][bus.fill_way_i] <= 1'b1;
                dirty_q[bus.fill_set_i][bus.fill_way_i] <= bus.fill_dirty_i;
                tag_q[bus.fill_set_i][bus.fill_way_i]   <= bus.fill_tag_i;
                for (int w = 0; w < NUM_WAYS; w++) age_q[bus.fill_set_i][w] <= fill_age[w];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            hit_q          <= 1'b0;
            miss_q         <= 1'b0;
            way_q          <= '0;
            victim_valid_q <= 1'b0;
            victim_dirty_q <= 1'b0;
            victim_tag_q   <= '0;
        end else begin
            hit_q          <= lookup_acc && lookup_hit;
            miss_q         <= lookup_acc && !lookup_hit;
            way_q          <= !lookup_acc ? '0 : (lookup_hit ? hit_way : victim_way);
            victim_valid_q <= lookup_acc && !lookup_hit && valid_q[bus.set_i][victim_way];
            victim_dirty_q <= lookup_acc && !lookup_hit && dirty_q[bus.set_i][victim_way];
            victim_tag_q   <= (lookup_acc && !lookup_hit) ? tag_q[bus.set_i][victim_way] : '0;
        end
    end

    assign bus.hit_o          = hit_q;
    assign bus.miss_o         = miss_q;
    assign bus.way_o          = way_q;
    assign bus.victim_valid_o = victim_valid_q;
    assign bus.victim_dirty_o = victim_dirty_q;
    assign bus.victim_tag_o   = victim_tag_q;
    assign bus.busy_o         = (state_q == StFlush);

endmodule

// File: tb/tb_segre_dcache_tag_sa.sv
// Scoreboard bench for segre_dcache_tag_sa: a recency-list cache model predicts each
// lookup result, a negedge monitor compares whatever the DUT presents.
module tb_segre_dcache_tag_sa;
    localparam int unsigned NUM_SETS = 4;
    localparam int unsigned NUM_WAYS = 4;
    localparam int unsigned TAG_SIZE = 8;

    logic clk_i = 1'b0;
    logic rsn_i = 1'b1;
    always #5 clk_i = ~clk_i;

    segre_dcache_tag_sa_if #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .TAG_SIZE(TAG_SIZE)) bus ();

    segre_dcache_tag_sa #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .TAG_SIZE(TAG_SIZE)) dut (
        .clk_i (clk_i),
        .rsn_i (rsn_i),
        .bus   (bus)
    );

    typedef struct {
        int due;
        bit hit;
        int way;
        bit vvalid;
        bit vdirty;
        int vtag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   flush_left = 0;

    // Model: per-line state plus a most-recent-first list of ways per set.
    bit m_valid [NUM_SETS][NUM_WAYS];
    bit m_dirty [NUM_SETS][NUM_WAYS];
    int m_tag   [NUM_SETS][NUM_WAYS];
    int m_order [NUM_SETS][$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void clear_set(int s);
        m_order[s].delete();
        for (int w = 0; w < NUM_WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_order[s].push_back(w);
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NUM_SETS; s++) begin
            clear_set(s);
            for (int w = 0; w < NUM_WAYS; w++) m_tag[s][w] = 0;
        end
    endfunction

    function automatic void touch(int s, int w);
        int idx = 0;
        for (int i = 0; i < m_order[s].size(); i++) if (m_order[s][i] == w) idx = i;
        m_order[s].delete(idx);
        m_order[s].push_front(w);
    endfunction

    function automatic exp_t model_lookup(int s, int t);
        exp_t e;
        int   n = 0;
        int   v = -1;
        e.hit = 0; e.way = 0; e.vvalid = 0; e.vdirty = 0; e.vtag = 0; e.due = 0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                n++;
                e.way = w;
            end
        end
        e.hit = (n == 1);
        if (!e.hit) begin
            for (int w = 0; w < NUM_WAYS; w++) if (v < 0 && !m_valid[s][w]) v = w;
            if (v < 0) v = m_order[s][NUM_WAYS-1];
            e.way    = v;
            e.vvalid = m_valid[s][v];
            e.vdirty = m_dirty[s][v];
            e.vtag   = m_tag[s][v];
        end
        return e;
    endfunction

    task automatic step(input bit req, input bit store, input int set, input int tag,
                        input bit fill, input int fset, input int fway, input int ftag,
                        input bit fdirty, input bit inv);
        exp_t e;
        bit   idle;
        idle = (flush_left == 0);
        bus.req_i        = req;
        bus.store_i      = store;
        bus.set_i        = set[1:0];
        bus.tag_i        = tag[7:0];
        bus.fill_i       = fill;
        bus.fill_set_i   = fset[1:0];
        bus.fill_way_i   = fway[1:0];
        bus.fill_tag_i   = ftag[7:0];
        bus.fill_dirty_i = fdirty;
        bus.invalidate_i = inv;
        e = model_lookup(set, tag);
        if (idle && req) begin
            e.due = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk_i);
        if (!idle) begin
            clear_set(NUM_SETS - flush_left);
            flush_left--;
        end else begin
            if (req && e.hit) begin
                if (!(fill && fset == set)) touch(set, e.way);
                if (store && !(fill && fset == set && fway == e.way)) m_dirty[set][e.way] = 1'b1;
            end
            if (fill) begin
                m_valid[fset][fway] = 1'b1;
                m_dirty[fset][fway] = fdirty;
                m_tag[fset][fway]   = ftag;
                touch(fset, fway);
            end
            if (inv) flush_left = NUM_SETS;
        end
        #1;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rsn_i = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_hit", 32'(bus.hit_o), 0);
        chk("rst_miss", 32'(bus.miss_o), 0);
        model_reset();
        sb.delete();
        flush_left = 0;
        @(posedge clk_i);
        #1;
        rsn_i = 1'b1;
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (rsn_i) begin
            chk("busy", 32'(bus.busy_o), 32'(flush_left > 0));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("hit", 32'(bus.hit_o), 32'(e.hit));
                chk("miss", 32'(bus.miss_o), 32'(!e.hit));
                chk("way", 32'(bus.way_o), 32'(e.way));
                if (!e.hit) begin
                    chk("victim_valid", 32'(bus.victim_valid_o), 32'(e.vvalid));
                    chk("victim_dirty", 32'(bus.victim_dirty_o), 32'(e.vdirty));
                    chk("victim_tag", 32'(bus.victim_tag_o), 32'(e.vtag));
                end
            end else if (bus.hit_o || bus.miss_o) begin
                chk("spurious_result", {30'd0, bus.hit_o, bus.miss_o}, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req_i = 0; bus.store_i = 0; bus.set_i = 0; bus.tag_i = 0;
        bus.fill_i = 0; bus.fill_set_i = 0; bus.fill_way_i = 0; bus.fill_tag_i = 0;
        bus.fill_dirty_i = 0; bus.invalidate_i = 0;
        model_reset();
        #2;
        do_reset();

        // Cold miss
        step(1, 0, 2, 8'h5A, 0, 0, 0, 0, 0, 0);
        idle_step();

        // Full set, hits then LRU eviction
        for (int w = 0; w < 4; w++) step(0, 0, 0, 0, 1, 1, w, 8'h10 + w, 0, 0);
        for (int t = 0; t < 3; t++) step(1, 0, 1, 8'h10 + t, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 8'h77, 0, 0, 0, 0, 0, 0);

        // Store marks dirty, later reported on eviction
        step(0, 0, 0, 0, 1, 0, 2, 8'hAB, 0, 0);
        step(1, 1, 0, 8'hAB, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 8'hC0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1, 8'hC1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 3, 8'hC3, 0, 0);
        step(1, 0, 0, 8'hEE, 0, 0, 0, 0, 0, 0);

        // Lookup sees pre-fill state
        step(1, 0, 3, 8'h44, 1, 3, 1, 8'h44, 0, 0);
        step(1, 0, 3, 8'h44, 0, 0, 0, 0, 0, 0);

        // Sweep: lookups during it ignored, everything invalid after
        for (int s = 0; s < 4; s++) step(0, 0, 0, 0, 1, s, 0, 8'h20 + s, 1, 0);
        step(1, 0, 0, 8'h20, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 1, i % 4, 8'h20 + (i % 4), 1, 0, 1, 8'h99, 1, 1);
        for (int s = 0; s < 4; s++) step(1, 0, s, 8'h20 + s, 0, 0, 0, 0, 0, 0);
        idle_step();

        // Reset aborts a sweep in progress
        for (int s = 0; s < 4; s++) step(0, 0, 0, 0, 1, s, 3, 8'h30 + s, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle_step();
        do_reset();
        for (int s = 0; s < 4; s++) step(1, 0, s, 8'h30 + s, 0, 0, 0, 0, 0, 0);

        // Randomized traffic over a small tag pool so hits and aliases occur
        for (int i = 0; i < 600; i++) begin
            step($urandom % 4 != 0, 1'($urandom % 2), int'($urandom % 4),
                 8'h10 + int'($urandom % 6), $urandom % 3 == 0, int'($urandom % 4),
                 int'($urandom % 4), 8'h10 + int'($urandom % 6), 1'($urandom % 2),
                 $urandom % 80 == 0);
        end

        for (int i = 0; i < NUM_SETS + 3; i++) idle_step();
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/segre_dcache_tag_sa.md
SEGRE_DCACHE_TAG_SA -- requirements
Module: segre_dcache_tag_sa

Interface
REQ-001 Parameter NUM_SETS, default 16, number of sets; SHALL be a power of two >= 2.
REQ-002 Parameter NUM_WAYS, default 4, ways per set; SHALL be a power of two >= 2.
REQ-003 Parameter TAG_SIZE, default DCACHE_TAG_SIZE, tag width; SET_SIZE = log2(NUM_SETS), WAY_SIZE = log2(NUM_WAYS) SHALL be derived localparams.
REQ-004 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rsn_i  in  1  reset, asynchronous, active-low.
REQ-006 req_i  in  1  lookup request for set_i/tag_i.
REQ-007 store_i  in  1  lookup is a store; qualifies req_i.
REQ-008 set_i  in  SET_SIZE  lookup set index.
REQ-009 tag_i  in  TAG_SIZE  lookup tag.
REQ-010 fill_i  in  1  write a line into fill_set_i/fill_way_i.
REQ-011 fill_set_i  in  SET_SIZE, fill_way_i  in  WAY_SIZE, fill_tag_i  in  TAG_SIZE, fill_dirty_i  in  1  fill target, tag and initial dirty bit.
REQ-012 invalidate_i  in  1  start global invalidate sweep.
REQ-013 hit_o  out  1, miss_o  out  1  registered lookup result.
REQ-014 way_o  out  WAY_SIZE  hit way on hit, victim way on miss.
REQ-015 victim_valid_o, victim_dirty_o  out  1 each; victim_tag_o  out  TAG_SIZE  victim line state, valid only with miss_o.
REQ-016 busy_o  out  1  invalidate sweep in progress.

Function
REQ-017 Per set and way, state SHALL be: valid, dirty, tag, age[WAY_SIZE]; ages within a set SHALL always be a permutation of 0..NUM_WAYS-1.
REQ-018 Lookup latency SHALL be 1 cycle: req_i at cycle N yields exactly one of hit_o/miss_o at N+1; both 0 when no accepted request at N.
REQ-019 Hit at N SHALL require exactly one way with valid=1 and tag==tag_i; way_o = that way in binary.
REQ-020 On hit, accessed way age SHALL become 0; ways with age below its old age SHALL increment; others unchanged.
REQ-021 On hit with store_i=1, dirty of the hit way SHALL be set at N+1.
REQ-022 On miss, victim SHALL be the lowest-index invalid way, else the way with age NUM_WAYS-1; way_o/victim_* SHALL reflect that way's state sampled at N. Miss SHALL NOT modify state.
REQ-023 fill_i SHALL write valid=1, tag=fill_tag_i, dirty=fill_dirty_i into the target and apply the REQ-020 age update to that set.
REQ-024 Lookup and fill same cycle: lookup SHALL see pre-fill state; if same set, only the fill age update SHALL apply; if the hit way equals the fill way, store dirty set SHALL be discarded (fill wins).
REQ-025 FSM states IDLE, FLUSH. IDLE->FLUSH on invalidate_i; FLUSH clears valid and dirty of set cnt and resets its ages to way index, cnt increments 0..NUM_SETS-1; FLUSH->IDLE after set NUM_SETS-1, cnt wraps to 0.
REQ-026 busy_o SHALL be 1 exactly in FLUSH (NUM_SETS cycles); req_i, fill_i and invalidate_i SHALL be ignored while busy_o=1.
REQ-027 invalidate_i with req_i/fill_i in the same IDLE cycle: req_i/fill_i SHALL be processed, sweep begins next cycle.

Reset
REQ-028 rsn_i low SHALL immediately force: all valid/dirty 0, tags 0, age[w]=w, FSM IDLE, cnt 0, all outputs 0.
REQ-029 Reset mid-FLUSH SHALL abort the sweep; after release busy_o=0 and no line is valid.

Verification (bench params NUM_SETS=4, NUM_WAYS=4, TAG_SIZE=8)
REQ-030 After reset, req set 2 tag 0x5A -> next cycle miss_o=1, way_o=0, victim_valid_o=0.
REQ-031 Fill set 1 ways 0..3 tags 0x10..0x13, lookup 0x10,0x11,0x12 -> all hit; then lookup 0x77 -> miss, way_o=3, victim_tag_o=0x13.
REQ-032 Fill set 0 way 2 tag 0xAB, store lookup 0xAB -> hit way_o=2; evict path later reports victim_dirty_o=1 for that way.
REQ-033 Same-cycle fill set 3 way 1 tag 0x44 and lookup set 3 tag 0x44 -> miss (pre-fill); lookup next cycle -> hit way_o=1.
REQ-034 Lines valid in all sets, pulse invalidate_i -> busy_o high 4 cycles, req_i ignored then; afterward every lookup misses with victim_valid_o=0.
REQ-035 Assert rsn_i low during cycle 2 of FLUSH -> busy_o=0 immediately, all lookups miss, ages per set = way index.
